// File: rtl/josebpswks_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
// The BCD digit type, the digit limits and the 7-segment codes live here.
package josebpswks_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_TENS = 4'd5;
    localparam bcd_t MAX_ONES = 4'd9;

    // Segment bit order: a=bit0 .. g=bit6, active-high
    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h6F;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

endpackage

// File: rtl/tt_um_josebpswks_seg7.sv
// Combinational BCD to 7-segment decoder; non-decimal codes blank the digit.
module seg7_decoder
    import josebpswks_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG7_BLANK;
        case (digit)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/tt_um_josebpswks.sv
// Tiny Tapeout MM:SS stopwatch: start/stop, clear, display select and test-mode tick.
// Define LAP_HOLD_EN to build the lap-hold latch driven by ui_in[2].
module tt_um_josebpswks
    import josebpswks_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    // Synchroniser lanes: {test, select, lap, clear, start}
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic       start_prev;

    logic          run;
    logic [PW-1:0] presc;
    mmss_t         cnt;
    mmss_t         cnt_inc;
    mmss_t         shown;

    logic start_edge;
    logic clear;
    logic lap;
    logic sel;
    logic test_mode;
    logic tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            start_prev <= 1'b0;
        end else begin
            sync1      <= {ui_in[7], ui_in[3:0]};
            sync2      <= sync1;
            start_prev <= sync2[0];
        end
    end

    assign start_edge = sync2[0] & ~start_prev;
    assign clear      = sync2[1];
    assign lap        = sync2[2];
    assign sel        = sync2[3];
    assign test_mode  = sync2[4];
    assign tick       = run & (test_mode | (presc == PRESC_MAX));

    // Ripple carry through the four BCD digits; 59:59 rolls over to 00:00
    always_comb begin
        cnt_inc = cnt;
        if (cnt.sec_ones != MAX_ONES) begin
            cnt_inc.sec_ones = cnt.sec_ones + 4'd1;
        end else begin
            cnt_inc.sec_ones = 4'd0;
            if (cnt.sec_tens != MAX_TENS) begin
                cnt_inc.sec_tens = cnt.sec_tens + 4'd1;
            end else begin
                cnt_inc.sec_tens = 4'd0;
                if (cnt.min_ones != MAX_ONES) begin
                    cnt_inc.min_ones = cnt.min_ones + 4'd1;
                end else begin
                    cnt_inc.min_ones = 4'd0;
                    if (cnt.min_tens != MAX_TENS) begin
                        cnt_inc.min_tens = cnt.min_tens + 4'd1;
                    end else begin
                        cnt_inc.min_tens = 4'd0;
                    end
                end
            end
        end
    end

    // Clear outranks both the start edge and the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            presc <= '0;
            cnt   <= '0;
        end else if (clear) begin
            run   <= 1'b0;
            presc <= '0;
            cnt   <= '0;
        end else begin
            if (start_edge) begin
                run <= ~run;
            end
            if (run) begin
                if (test_mode || presc == PRESC_MAX) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
            if (tick) begin
                cnt <= cnt_inc;
            end
        end
    end

`ifdef LAP_HOLD_EN
    mmss_t lap_latch;

    // Tracks the live count until lap goes high, then freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_latch <= '0;
        end else if (clear) begin
            lap_latch <= '0;
        end else if (!lap) begin
            lap_latch <= cnt;
        end
    end

    assign shown = lap ? lap_latch : cnt;
`else
    assign shown = cnt;
`endif

    bcd_t       disp_tens;
    bcd_t       disp_ones;
    logic [6:0] seg;

    assign disp_tens = sel ? shown.min_tens : shown.sec_tens;
    assign disp_ones = sel ? shown.min_ones : shown.sec_ones;

    seg7_decoder u_seg (
        .digit (disp_ones),
        .seg   (seg)
    );

    assign uo_out  = {run, seg};
    assign uio_out = {disp_tens, disp_ones};
    assign uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[6:4], lap};

endmodule

// File: tb/tb_tt_um_josebpswks.sv
// Directed bench for the stopwatch top; expectations come from a seconds-count
// model and are queued before each step, then popped when the outputs are sampled.
module tb_tt_um_josebpswks;

    localparam int CLK_HZ = 8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_josebpswks #(.CLK_HZ(CLK_HZ)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] uio;
        logic [7:0] uo;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int n_total = 0;
    int n_pass  = 0;
    int model_secs = 0;
    bit model_run  = 1'b0;
    bit model_sel  = 1'b0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected outputs when the display shows a given seconds value
    task automatic push_secs(input string tag, input int secs);
        exp_t e;
        int   n;
        n     = model_sel ? (secs / 60) : (secs % 60);
        e.tag = tag;
        e.uio = {4'(n / 10), 4'(n % 10)};
        e.uo  = {model_run, seg_tab[n % 10]};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_total += 2;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed uio=%h uo=%h", uio_out, uo_out);
        end else begin
            e = sb.pop_front();
            assert (uio_out === e.uio) n_pass++;
            else $error("FAIL %s uio_out observed=%h expected=%h", e.tag, uio_out, e.uio);
            assert (uo_out === e.uo) n_pass++;
            else $error("FAIL %s uo_out observed=%h expected=%h", e.tag, uo_out, e.uo);
        end
    endtask

    task automatic check_oe(input string tag);
        n_total++;
        assert (uio_oe === 8'hFF) n_pass++;
        else $error("FAIL %s uio_oe observed=%h expected=ff", tag, uio_oe);
    endtask

    // Steps n cycles while running in test mode: one tick per edge
    task automatic tick_check(input int n, input string tag);
        model_secs = (model_secs + n) % 3600;
        push_secs(tag, model_secs);
        step(n);
        pop_check();
        $display("txn %-14s secs=%0d sel=%0d run=%0d uio=%h uo=%h",
                 tag, model_secs, model_sel, model_run, uio_out, uo_out);
    endtask

    task automatic hold_check(input int n, input string tag);
        push_secs(tag, model_secs);
        step(n);
        pop_check();
        $display("txn %-14s secs=%0d sel=%0d run=%0d uio=%h uo=%h",
                 tag, model_secs, model_sel, model_run, uio_out, uo_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset hold and release
        hold_check(3, "rst_hold");
        check_oe("rst_oe");
        rst_n = 1'b1;
        hold_check(2, "rst_release");

        // Test mode, start pulse: run rises on the 3rd edge, then one tick per edge
        ui_in[7] = 1'b1;
        step(3);
        ui_in[0] = 1'b1;
        hold_check(2, "start_edge2");
        model_run = 1'b1;
        hold_check(1, "start_edge3");
        ui_in[0] = 1'b0;
        tick_check(1, "tick1");
        tick_check(4, "tick5");

        // Full-hour wrap and minutes display
        tick_check(3594, "tick3599_sec");
        tick_check(1, "wrap_3600");
        ui_in[3] = 1'b1;
        model_sel = 1'b1;
        tick_check(2, "sel_min_00");
        tick_check(752, "min_12");
        tick_check(2845, "tick3599_min");
        ui_in[3] = 1'b0;
        model_sel = 1'b0;
        tick_check(2, "sel_sec_back");

        // Clear at 00:12 with a simultaneous start pulse
        tick_check(9, "pre_clear");
        ui_in[1] = 1'b1;
        ui_in[0] = 1'b1;
        tick_check(2, "clear_sync");
        model_secs = 0;
        model_run  = 1'b0;
        hold_check(1, "clear_apply");
        hold_check(5, "clear_hold");
        ui_in[1] = 1'b0;
        ui_in[0] = 1'b0;
        hold_check(5, "clear_release");

        // Prescaler: one tick per CLK_HZ running cycles, held while stopped
        ui_in[7] = 1'b0;
        step(3);
        ui_in[0] = 1'b1;
        model_run = 1'b1;
        hold_check(3, "ps_start");
        ui_in[0] = 1'b0;
        hold_check(CLK_HZ - 1, "ps_before_tick");
        tick_check(1, "ps_first_tick");
        model_secs = model_secs + 2;
        push_secs("ps_third_tick", model_secs);
        step(2 * CLK_HZ);
        pop_check();
        ui_in[0] = 1'b1;
        model_run = 1'b0;
        hold_check(3, "stop_at_03");
        ui_in[0] = 1'b0;
        hold_check(100, "stop_hold100");
        ui_in[0] = 1'b1;
        model_run = 1'b1;
        hold_check(3, "resume");
        ui_in[0] = 1'b0;
        hold_check(4, "resume_presc");
        tick_check(1, "resume_tick");

        // Clear while stopped-or-running, then back to test mode
        ui_in[1] = 1'b1;
        model_secs = 0;
        model_run  = 1'b0;
        hold_check(3, "clear2");
        ui_in[1] = 1'b0;
        ui_in[7] = 1'b1;
        step(3);
        ui_in[0] = 1'b1;
        model_run = 1'b1;
        hold_check(3, "lap_start");
        ui_in[0] = 1'b0;
        tick_check(6, "pre_lap");

`ifdef LAP_HOLD_EN
        // Latch freezes the count seen on the edge where synced lap rises
        ui_in[2] = 1'b1;
        model_secs = model_secs + 2;
        push_secs("lap_freeze", 7);
        step(2);
        pop_check();
        model_secs = model_secs + 7;
        push_secs("lap_hold", 7);
        step(7);
        pop_check();
        ui_in[2] = 1'b0;
        model_secs = model_secs + 1;
        push_secs("lap_release1", 7);
        step(1);
        pop_check();
        tick_check(1, "lap_live_17");
`else
        ui_in[2] = 1'b1;
        tick_check(2, "lap_ignored");
        tick_check(10, "lap_ignored2");
        ui_in[2] = 1'b0;
`endif

        // Asynchronous reset mid-cycle while running
        #3;
        rst_n = 1'b0;
        model_secs = 0;
        model_run  = 1'b0;
        model_sel  = 1'b0;
        push_secs("async_reset", 0);
        #1;
        pop_check();
        check_oe("async_oe");
        $display("txn %-14s uio=%h uo=%h", "async_reset", uio_out, uo_out);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
